// File: rtl/div_rr_scheduler.sv
// Round-robin front end sharing one pipelined signed divider among NREQ requesters.
// A tag pipeline shadows the divider so each result is steered back to its issuer.
module div_rr_scheduler #(
    parameter int N       = 8,
    parameter int M       = 8,
    parameter int NREQ    = 4,
    parameter int LATENCY = N + 2
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic [NREQ-1:0]     req_valid_i,
    output logic [NREQ-1:0]     req_ready_o,
    input  logic [NREQ*N-1:0]   req_dividend_i,
    input  logic [NREQ*M-1:0]   req_divisor_i,
    output logic                div_valid_o,
    output logic [N-1:0]        div_dividend_o,
    output logic [M-1:0]        div_divisor_o,
    input  logic                div_valid_i,
    input  logic [N-1:0]        div_quotient_i,
    input  logic [M-1:0]        div_remainder_i,
    output logic [NREQ-1:0]     rsp_valid_o,
    output logic [N-1:0]        rsp_quotient_o,
    output logic [M-1:0]        rsp_remainder_o,
    output logic                rsp_dz_o,
    output logic                busy_o,
    output logic                sync_err_o
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(LATENCY + 3);

    logic [PW-1:0]   ptr_reg;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gnt_id;
    logic            gnt_found;
    logic            handshake;
    logic [N-1:0]    dividend_arr [NREQ];
    logic [M-1:0]    divisor_arr  [NREQ];
    logic [PW-1:0]   issue_id_reg;
    logic            issue_dz_reg;
    logic            tag_valid_reg [LATENCY];
    logic [PW-1:0]   tag_id_reg    [LATENCY];
    logic            tag_dz_reg    [LATENCY];
    logic            tag_out_valid;
    logic [PW-1:0]   tag_out_id;
    logic            tag_out_dz;
    logic [NREQ-1:0] rsp_hit;
    logic [CW-1:0]   count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign dividend_arr[gi] = req_dividend_i[gi*N +: N];
            assign divisor_arr[gi]  = req_divisor_i[gi*M +: M];
            assign rsp_hit[gi]      = div_valid_i & tag_out_valid & (tag_out_id == PW'(gi));
        end
    endgenerate

    // Search from ptr upward, wrapping modulo NREQ; first asserted valid wins.
    always_comb begin : arb_comb
        logic [PW:0] cand;
        grant     = '0;
        gnt_id    = '0;
        gnt_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_reg} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!gnt_found && req_valid_i[cand[PW-1:0]]) begin
                gnt_found                = 1'b1;
                grant[cand[PW-1:0]]      = 1'b1;
                gnt_id                   = cand[PW-1:0];
            end
        end
    end

    assign req_ready_o = (en_i && rst_n_i) ? grant : '0;
    assign handshake   = en_i & gnt_found;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_reg        <= '0;
            div_valid_o    <= 1'b0;
            div_dividend_o <= '0;
            div_divisor_o  <= '0;
            issue_id_reg   <= '0;
            issue_dz_reg   <= 1'b0;
        end else begin
            div_valid_o <= handshake;
            if (handshake) begin
                ptr_reg        <= (gnt_id == PW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
                div_dividend_o <= dividend_arr[gnt_id];
                div_divisor_o  <= divisor_arr[gnt_id];
                issue_id_reg   <= gnt_id;
                issue_dz_reg   <= (divisor_arr[gnt_id] == '0);
            end else begin
                issue_id_reg   <= '0;
                issue_dz_reg   <= 1'b0;
            end
        end
    end

    // The issue register is the head of the tag pipe; LATENCY more stages match the divider.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < LATENCY; k++) begin
                tag_valid_reg[k] <= 1'b0;
                tag_id_reg[k]    <= '0;
                tag_dz_reg[k]    <= 1'b0;
            end
        end else begin
            tag_valid_reg[0] <= div_valid_o;
            tag_id_reg[0]    <= issue_id_reg;
            tag_dz_reg[0]    <= issue_dz_reg;
            for (int k = 1; k < LATENCY; k++) begin
                tag_valid_reg[k] <= tag_valid_reg[k-1];
                tag_id_reg[k]    <= tag_id_reg[k-1];
                tag_dz_reg[k]    <= tag_dz_reg[k-1];
            end
        end
    end

    assign tag_out_valid = tag_valid_reg[LATENCY-1];
    assign tag_out_id    = tag_id_reg[LATENCY-1];
    assign tag_out_dz    = tag_dz_reg[LATENCY-1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_o     <= '0;
            rsp_quotient_o  <= '0;
            rsp_remainder_o <= '0;
            rsp_dz_o        <= 1'b0;
            sync_err_o      <= 1'b0;
            count_reg       <= '0;
        end else begin
            rsp_valid_o <= rsp_hit;
            if (|rsp_hit) begin
                rsp_quotient_o  <= tag_out_dz ? '0 : div_quotient_i;
                rsp_remainder_o <= tag_out_dz ? '0 : div_remainder_i;
                rsp_dz_o        <= tag_out_dz;
            end
            if (tag_out_valid != div_valid_i) begin
                sync_err_o <= 1'b1;
            end
            case ({handshake, |rsp_valid_o})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign busy_o = (count_reg != '0);

endmodule

// File: doc/div_rr_scheduler.md
# div_rr_scheduler

Round-robin scheduler that shares one fully pipelined signed divider (latency LATENCY cycles, no backpressure) among NREQ requesters. It accepts requests through per-requester valid/ready handshakes and issues at most one divide per cycle. A tag pipeline runs in parallel with the divider and carries each request's requester ID, so every result is returned to the requester that issued it. The block sits between the requesting units and the divider instance, and flags divide-by-zero and tag/valid misalignment.

## Interface
- N, 8, dividend/quotient width
- M, 8, divisor/remainder width
- NREQ, 4, number of requesters (≥2)
- LATENCY, N+2, divider latency from divider valid_i to valid_o, in cycles
- clk_i  in  1  clock; all logic on the rising edge
- rst_n_i  in  1  reset, asynchronous, active-low; the same reset drives the divider
- en_i  in  1  grant enable; when low, no new requests are accepted
- req_valid_i  in  NREQ  per-requester request valid
- req_ready_o  out  NREQ  per-requester grant; one-hot or zero
- req_dividend_i  in  NREQ*N  packed dividends; requester i occupies [i*N +: N], signed
- req_divisor_i  in  NREQ*M  packed divisors; requester i occupies [i*M +: M], signed
- div_valid_o  out  1  issue strobe to the divider
- div_dividend_o  out  N  registered dividend to the divider
- div_divisor_o  out  M  registered divisor to the divider
- div_valid_i  in  1  divider result valid
- div_quotient_i  in  N  divider quotient
- div_remainder_i  in  M  divider remainder
- rsp_valid_o  out  NREQ  one-hot result strobe; no backpressure, the requester must take it
- rsp_quotient_o  out  N  result quotient, shared by all requesters
- rsp_remainder_o  out  M  result remainder, shared by all requesters
- rsp_dz_o  out  1  the current result came from a divisor of 0
- busy_o  out  1  at least one request is in flight
- sync_err_o  out  1  sticky flag: div_valid_i disagreed with the tag pipeline

## Operation
- **Arbitration.** The arbiter is combinational round-robin.
  - Priority pointer ptr has width clog2(NREQ) and resets to 0.
  - The grant goes to the first i with req_valid_i[i]=1, searching i = ptr, ptr+1, … modulo NREQ.
  - req_ready_o[i] = en_i & grant[i]. It depends combinationally on req_valid_i; requesters must not make valid depend on ready.
  - A handshake is req_valid_i[i] & req_ready_o[i]. On a handshake, ptr ← (i+1) mod NREQ, wrapping NREQ-1 → 0. Otherwise ptr holds.
- **Issue.** A handshake registers the granted operands into div_dividend_o and div_divisor_o, sets div_valid_o=1 for one cycle, and pushes a tag {valid=1, id=i, dz=(divisor==0)}.
  - With no handshake: div_valid_o=0 and a null tag is pushed.
  - Operand registers hold their last value when no handshake occurs.
- **Tag pipeline.** It is a shift register of depth LATENCY, aligned with the divider.
  - Tag out valid ≠ div_valid_i in any cycle sets sync_err_o. The flag clears only on reset.
- **Response.** This is a registered stage.
  - When div_valid_i & tag.valid, drive rsp_valid_o[tag.id]=1, rsp_quotient_o=div_quotient_i, rsp_remainder_o=div_remainder_i, rsp_dz_o=tag.dz.
  - If tag.dz=1, force quotient and remainder to 0 regardless of the divider output.
  - Otherwise rsp_valid_o=0. Data outputs hold their last value.
- **Arithmetic.** The divider quotient truncates toward zero; the remainder takes the dividend's sign. The scheduler passes both through unchanged.
- **Outstanding counter.** Width clog2(LATENCY+3). It increments on a handshake and decrements on a response strobe. Simultaneous handshake and response leaves it unchanged. busy_o = (count≠0).
- **Enable low.** en_i=0 stops grants only. In-flight work completes, and ptr holds.
- **Reset mid-operation.** Everything clears asynchronously and in-flight requests are discarded with no response. Reset values of all outputs and state: req_ready_o=0, div_valid_o=0, div operands=0, rsp_valid_o=0, rsp data=0, rsp_dz_o=0, busy_o=0, sync_err_o=0, ptr=0, tags null, count=0.

## Timing
- Handshake in cycle t → div_valid_o high in cycle t+1 → divider result in cycle t+1+LATENCY → rsp_valid_o in cycle t+2+LATENCY.
- Total latency is LATENCY+2 cycles, which is 12 at the defaults.
- Throughput is one request per cycle in aggregate. Responses return in issue order.
- One requester holding req_valid_i high while others also request is granted at most once every NREQ cycles.
- A lone requester is granted every cycle.

## Test plan
- **Single request.** Requester 2 sends −7 / 2 at t=0 → rsp_valid_o=4'b0100 at t=12 with quotient −3, remainder −1, rsp_dz_o=0.
- **All requesting at once.** All four hold valid from t=0 with distinct operands, e.g. 100/7, −100/7, 100/−7, −128/1 → grants in order 0,1,2,3 in cycles 0–3. Responses return to 0,1,2,3 in cycles 12–15 with quotient/remainder pairs (14,2), (−14,−2), (−14,2), (−128,0).
- **Fairness.** Requester 0 requests continuously while requester 3 requests from t=5 → requester 3 is granted at t=5 or t=6, and requester 0 never gets two consecutive grants while requester 3 waits.
- **Divide by zero.** Requester 1 sends 55 / 0 → rsp_dz_o=1 with quotient=0 and remainder=0 at t+12. sync_err_o stays 0.
- **Enable and busy.** en_i=0 with all valids high → req_ready_o=0 with no issue. Raise en_i after 3 requests have been issued → busy_o stays 1 until the third response, then falls to 0.
- **Reset and sync error.** Assert rst_n_i at t=4 with 3 requests in flight → all outputs are 0 immediately and no responses appear afterwards. Separately, inject a spurious div_valid_i while all tags are null → sync_err_o rises to 1 and stays there.
